m_csr_trap_unit: RTL and testbench
==================================

# m_csr_trap_unit

Parametrised machine-mode CSR file with hardware trap entry, `mret` return and performance counters, for the pipeline's exception-control stage. It generalises the plain M-mode CSR register file to XLEN 32/64, a configurable PMP address count and WARL legalisation. It updates `mepc`/`mcause`/`mtval`/`mstatus` autonomously on exceptions from the F/D and E/M pipeline registers. It supplies the trap target and return PC to the fetch redirect logic.

## Interface
- `XLEN`, default `` `XLEN_64b `` (2); data width W = 1<<(XLEN+4), so 1 gives 32 and 2 gives 64.
- `NUM_PMP_ADDR`, default 16; pmpaddr0..N-1 at 0x3B0+i, N ≤ 64.
- `NO_E`, default 4'hF; exception code meaning "no exception".
- `RESET_MTVEC`, default 0; reset value of `mtvec`.
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_clk_en` in 1: global stall; when low, no state changes, counters included.
- `i_csr_read_addr` in 12: combinational read address.
- `o_csr_data` out W: read data.
- `i_csr_write_addr` in 12, `i_csr_write_enable` in 1, `i_csr_data` in W: software write port.
- `i_exception_code_f_d_ff` in 4, `i_exception_pc_f_d_ff` in W: fetch/decode exception.
- `i_exception_code_e_m_ff` in 4, `i_exception_pc_e_m_ff` in W, `i_exception_addr_e_m_ff` in W: execute/memory exception and faulting address.
- `i_mret_e` in 1: `mret` executing.
- `i_instret` in 1: one instruction retired this cycle.
- `o_trap_taken` out 1: registered one-cycle pulse after trap entry.
- `o_mtvec` out W: trap target {mtvec[W-1:2],2'b00}.
- `o_mepc` out W: return PC.
- `o_UXL` out 2: mstatus.UXL in 64b; equals XLEN in 32b.
- `o_illegal_csr` out 1: combinational; read address unimplemented, or write enabled to a read-only/unimplemented address.

## Operation
- Event priority per enabled cycle, highest first:
  - E/M exception (older instruction).
  - F/D exception.
  - `mret`.
  - Software write.
  - Only the winner updates architectural CSRs; a losing software write is dropped.
- Trap entry (code ≠ NO_E):
  - mepc ← pc with bit0 cleared.
  - mcause ← {0, zero-extended code}.
  - mtval ← F/D pc, or E/M addr.
  - mstatus.MPIE(7) ← MIE(3); MIE ← 0; MPP[12:11] stays 2'b11.
- `mret`: MIE ← MPIE, MPIE ← 1.
- WARL rules:
  - mtvec write with mode[1:0] ≥ 2 keeps the old mode and takes the new base.
  - mepc bit0 is forced to 0.
  - mstatus: only MIE and MPIE are writable; MPP reads 2'b11; UXL reads 2'b10 in 64b.
  - misa is read-only: MXL=XLEN in the top 2 bits, bit 8 (I) set.
- Read-only registers: 0xF11–0xF15 (mvendorid, marchid, mimpid, mhartid, mconfigptr) read 0; writes are ignored and raise `o_illegal_csr`.
- Counters:
  - mcycle (0xB00) and minstret (0xB02) are always 64-bit.
  - In 32b mode, the upper halves are at 0xB80/0xB82.
  - mcycle increments every enabled cycle; minstret increments on `i_instret`.
  - mcountinhibit (0x320) bit0 inhibits mcycle; bit2 inhibits minstret.
  - A software write to a counter (either half) beats the increment that cycle.
  - Counters wrap from all-ones to 0.
- Other CSRs (medeleg, mideleg, mie, mip, mscratch, mcause, mtval, menvcfg, mseccfg, pmpcfg0–15, pmpaddr):
  - Fully writable, W-bit registers.
  - pmpaddr ≥ NUM_PMP_ADDR reads 0 and flags illegal.
  - In 64b mode, odd pmpcfg addresses flag illegal.
- Unimplemented read addresses return 0.

## Timing
- Reads are combinational from current state.
- Writes, trap entry and `mret` take effect at the next rising edge; `o_mepc`/`o_mtvec` reflect them the following cycle.
- `o_trap_taken` rises one cycle after the trap cycle and lasts exactly one cycle. It is cleared on a stall cycle.
- Reset values (asynchronous):
  - All CSRs 0, except mtvec = RESET_MTVEC and the constant fields above (misa, MPP, UXL).
  - `o_trap_taken` 0.
  - Reset mid-trap aborts the trap; no partial update survives.
- Simultaneous F/D and E/M exceptions: only E/M is recorded, and one pulse is issued.

## Test plan
- Reset, then read 0x300 and 0x301 (XLEN=2) → 0x2_0000_1800 and 0x8000_0000_0000_0100; read 0x305 → RESET_MTVEC.
- Write mtvec 0x8000_0003 → reads 0x8000_0000 (mode kept 0); `o_mtvec` is 0x8000_0000 next cycle.
- Set MIE, then raise E/M code 5 with pc 0x100, addr 0xDEAD together with F/D code 2 → mepc=0x100, mcause=5, mtval=0xDEAD, MIE=0, MPIE=1, one `o_trap_taken` pulse. Then `i_mret_e` → MIE=1.
- Exception and software write to mscratch in the same cycle → mscratch unchanged.
- 10 enabled cycles with 4 `i_instret` pulses and 3 stall cycles → mcycle=10, minstret=4. With mcountinhibit=5, both counters are frozen.
- Write 0xF14 or read 0x3FF (NUM_PMP_ADDR=16) → `o_illegal_csr`=1, data 0, no state change.

Source files
------------

// File: rtl/m_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module      : m_csr_trap_unit
// Description : Machine-mode CSR file with hardware trap entry, mret return
//               and 64-bit performance counters for the exception-control
//               stage. XLEN selects 32b (1) or 64b (2) data width.
// Ports       : i_clk/i_rst/i_clk_en      clock, async reset, global stall
//               i_csr_read_addr/o_csr_data combinational read port
//               i_csr_write_*             software write port
//               i_exception_*             F/D and E/M exception sources
//               i_mret_e, i_instret       mret and retire strobes
//               o_trap_taken              one-cycle pulse after trap entry
//               o_mtvec/o_mepc/o_UXL      fetch redirect and status outputs
//               o_illegal_csr             illegal access flag
// Revision    : 1.0 - initial release
// ============================================================================
module m_csr_trap_unit #(
  parameter int unsigned  XLEN         = 2,
  parameter int unsigned  NUM_PMP_ADDR = 16,
  parameter logic [3:0]   NO_E         = 4'hF,
  parameter logic [63:0]  RESET_MTVEC  = 64'h0,
  localparam int unsigned W            = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic [11:0]  i_csr_read_addr,
  output logic [W-1:0] o_csr_data,
  input  logic [11:0]  i_csr_write_addr,
  input  logic         i_csr_write_enable,
  input  logic [W-1:0] i_csr_data,
  input  logic [3:0]   i_exception_code_f_d_ff,
  input  logic [W-1:0] i_exception_pc_f_d_ff,
  input  logic [3:0]   i_exception_code_e_m_ff,
  input  logic [W-1:0] i_exception_pc_e_m_ff,
  input  logic [W-1:0] i_exception_addr_e_m_ff,
  input  logic         i_mret_e,
  input  logic         i_instret,
  output logic         o_trap_taken,
  output logic [W-1:0] o_mtvec,
  output logic [W-1:0] o_mepc,
  output logic [1:0]   o_UXL,
  output logic         o_illegal_csr
);

  localparam bit c_IS64 = (W == 64);

  localparam logic [11:0] c_ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] c_ADDR_MISA          = 12'h301;
  localparam logic [11:0] c_ADDR_MEDELEG       = 12'h302;
  localparam logic [11:0] c_ADDR_MIDELEG       = 12'h303;
  localparam logic [11:0] c_ADDR_MIE           = 12'h304;
  localparam logic [11:0] c_ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] c_ADDR_MENVCFG       = 12'h30A;
  localparam logic [11:0] c_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] c_ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] c_ADDR_MEPC          = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] c_ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] c_ADDR_MIP           = 12'h344;
  localparam logic [11:0] c_ADDR_PMPCFG0       = 12'h3A0;
  localparam logic [11:0] c_ADDR_PMPADDR0      = 12'h3B0;
  localparam logic [11:0] c_ADDR_MSECCFG       = 12'h747;
  localparam logic [11:0] c_ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] c_ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] c_ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] c_ADDR_MINSTRETH     = 12'hB82;

  // misa: MXL in the top two bits, I extension (bit 8).
  localparam logic [W-1:0] c_MISA = {2'(XLEN), {(W-2){1'b0}}} | W'(12'h100);
  // Constant mstatus fields: MPP=2'b11, and UXL=2'b10 in 64b.
  localparam logic [63:0]  c_MSTATUS_FIXED64 = c_IS64 ? 64'h2_0000_1800 : 64'h1800;
  localparam logic [W-1:0] c_MSTATUS_FIXED   = c_MSTATUS_FIXED64[W-1:0];

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic         mstatus_mie_q,  mstatus_mie_d;
  logic         mstatus_mpie_q, mstatus_mpie_d;
  logic [W-1:0] medeleg_q,      medeleg_d;
  logic [W-1:0] mideleg_q,      mideleg_d;
  logic [W-1:0] mie_q,          mie_d;
  logic [W-1:0] mtvec_q,        mtvec_d;
  logic [W-1:0] menvcfg_q,      menvcfg_d;
  logic [W-1:0] mcountinhibit_q, mcountinhibit_d;
  logic [W-1:0] mscratch_q,     mscratch_d;
  logic [W-1:0] mepc_q,         mepc_d;
  logic [W-1:0] mcause_q,       mcause_d;
  logic [W-1:0] mtval_q,        mtval_d;
  logic [W-1:0] mip_q,          mip_d;
  logic [W-1:0] mseccfg_q,      mseccfg_d;
  logic [W-1:0] pmpcfg_q  [16];
  logic [W-1:0] pmpcfg_d  [16];
  logic [W-1:0] pmpaddr_q [NUM_PMP_ADDR];
  logic [W-1:0] pmpaddr_d [NUM_PMP_ADDR];
  logic [63:0]  mcycle_q,       mcycle_d;
  logic [63:0]  minstret_q,     minstret_d;
  logic         trap_taken_q,   trap_taken_d;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  function automatic logic f_is_pmpcfg(input logic [11:0] a);
    // In 64b the odd pmpcfg registers do not exist.
    return (a[11:4] == c_ADDR_PMPCFG0[11:4]) && (!c_IS64 || !a[0]);
  endfunction

  function automatic logic f_is_pmpaddr(input logic [11:0] a);
    return (a >= c_ADDR_PMPADDR0) &&
           (int'(a) < int'(c_ADDR_PMPADDR0) + int'(NUM_PMP_ADDR));
  endfunction

  function automatic logic f_is_read_only(input logic [11:0] a);
    return (a == c_ADDR_MISA) || ((a >= 12'hF11) && (a <= 12'hF15));
  endfunction

  function automatic logic f_is_implemented(input logic [11:0] a);
    logic hit;
    case (a)
      c_ADDR_MSTATUS, c_ADDR_MISA, c_ADDR_MEDELEG, c_ADDR_MIDELEG,
      c_ADDR_MIE, c_ADDR_MTVEC, c_ADDR_MENVCFG, c_ADDR_MCOUNTINHIBIT,
      c_ADDR_MSCRATCH, c_ADDR_MEPC, c_ADDR_MCAUSE, c_ADDR_MTVAL,
      c_ADDR_MIP, c_ADDR_MSECCFG, c_ADDR_MCYCLE, c_ADDR_MINSTRET:
        hit = 1'b1;
      c_ADDR_MCYCLEH, c_ADDR_MINSTRETH:
        hit = !c_IS64;
      default:
        hit = f_is_read_only(a) || f_is_pmpcfg(a) || f_is_pmpaddr(a);
    endcase
    return hit;
  endfunction

  logic w_read_ok;
  logic w_write_ok;

  assign w_read_ok     = f_is_implemented(i_csr_read_addr);
  assign w_write_ok    = f_is_implemented(i_csr_write_addr) && !f_is_read_only(i_csr_write_addr);
  assign o_illegal_csr = !w_read_ok || (i_csr_write_enable && !w_write_ok);

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [W-1:0] w_mstatus;

  assign w_mstatus = c_MSTATUS_FIXED
                   | (W'(mstatus_mie_q)  << 3)
                   | (W'(mstatus_mpie_q) << 7);

  always_comb begin
    o_csr_data = '0;
    case (i_csr_read_addr)
      c_ADDR_MSTATUS:       o_csr_data = w_mstatus;
      c_ADDR_MISA:          o_csr_data = c_MISA;
      c_ADDR_MEDELEG:       o_csr_data = medeleg_q;
      c_ADDR_MIDELEG:       o_csr_data = mideleg_q;
      c_ADDR_MIE:           o_csr_data = mie_q;
      c_ADDR_MTVEC:         o_csr_data = mtvec_q;
      c_ADDR_MENVCFG:       o_csr_data = menvcfg_q;
      c_ADDR_MCOUNTINHIBIT: o_csr_data = mcountinhibit_q;
      c_ADDR_MSCRATCH:      o_csr_data = mscratch_q;
      c_ADDR_MEPC:          o_csr_data = mepc_q;
      c_ADDR_MCAUSE:        o_csr_data = mcause_q;
      c_ADDR_MTVAL:         o_csr_data = mtval_q;
      c_ADDR_MIP:           o_csr_data = mip_q;
      c_ADDR_MSECCFG:       o_csr_data = mseccfg_q;
      c_ADDR_MCYCLE:        o_csr_data = mcycle_q[W-1:0];
      c_ADDR_MINSTRET:      o_csr_data = minstret_q[W-1:0];
      c_ADDR_MCYCLEH:       o_csr_data = c_IS64 ? '0 : W'(mcycle_q[63:32]);
      c_ADDR_MINSTRETH:     o_csr_data = c_IS64 ? '0 : W'(minstret_q[63:32]);
      default: begin
        // Read-only IDs and unimplemented addresses fall through as 0.
        for (int i = 0; i < 16; i++) begin
          if (f_is_pmpcfg(i_csr_read_addr) && (i_csr_read_addr[3:0] == 4'(i)))
            o_csr_data = pmpcfg_q[i];
        end
        for (int i = 0; i < NUM_PMP_ADDR; i++) begin
          if (i_csr_read_addr == c_ADDR_PMPADDR0 + 12'(i))
            o_csr_data = pmpaddr_q[i];
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Event arbitration: E/M trap > F/D trap > mret > software write
  // --------------------------------------------------------------------------
  logic         w_em_exc;
  logic         w_fd_exc;
  logic         w_trap;
  logic [3:0]   w_trap_code;
  logic [W-1:0] w_trap_pc;
  logic [W-1:0] w_trap_val;
  logic         w_sw_write;
  logic [63:0]  w_wdata64;

  assign w_em_exc    = (i_exception_code_e_m_ff != NO_E);
  assign w_fd_exc    = (i_exception_code_f_d_ff != NO_E);
  assign w_trap      = w_em_exc || w_fd_exc;
  assign w_trap_code = w_em_exc ? i_exception_code_e_m_ff : i_exception_code_f_d_ff;
  assign w_trap_pc   = w_em_exc ? i_exception_pc_e_m_ff   : i_exception_pc_f_d_ff;
  assign w_trap_val  = w_em_exc ? i_exception_addr_e_m_ff : i_exception_pc_f_d_ff;
  assign w_sw_write  = i_csr_write_enable && w_write_ok;
  assign w_wdata64   = 64'(i_csr_data);

  always_comb begin
    mstatus_mie_d   = mstatus_mie_q;
    mstatus_mpie_d  = mstatus_mpie_q;
    medeleg_d       = medeleg_q;
    mideleg_d       = mideleg_q;
    mie_d           = mie_q;
    mtvec_d         = mtvec_q;
    menvcfg_d       = menvcfg_q;
    mcountinhibit_d = mcountinhibit_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    mip_d           = mip_q;
    mseccfg_d       = mseccfg_q;
    for (int i = 0; i < 16; i++)           pmpcfg_d[i]  = pmpcfg_q[i];
    for (int i = 0; i < NUM_PMP_ADDR; i++) pmpaddr_d[i] = pmpaddr_q[i];
    mcycle_d        = mcycle_q;
    minstret_d      = minstret_q;
    trap_taken_d    = 1'b0;

    if (i_clk_en) begin
      trap_taken_d = w_trap;

      // Increments first; a winning software write below overrides them.
      if (!mcountinhibit_q[0])
        mcycle_d = mcycle_q + 64'd1;
      if (!mcountinhibit_q[2] && i_instret)
        minstret_d = minstret_q + 64'd1;

      if (w_trap) begin
        mepc_d         = {w_trap_pc[W-1:1], 1'b0};
        mcause_d       = W'(w_trap_code);
        mtval_d        = w_trap_val;
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
      end else if (i_mret_e) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end else if (w_sw_write) begin
        case (i_csr_write_addr)
          c_ADDR_MSTATUS: begin
            mstatus_mie_d  = i_csr_data[3];
            mstatus_mpie_d = i_csr_data[7];
          end
          c_ADDR_MEDELEG:       medeleg_d       = i_csr_data;
          c_ADDR_MIDELEG:       mideleg_d       = i_csr_data;
          c_ADDR_MIE:           mie_d           = i_csr_data;
          // Reserved modes (>= 2) keep the previous mode, base always updates.
          c_ADDR_MTVEC:         mtvec_d = {i_csr_data[W-1:2],
                                           (i_csr_data[1:0] >= 2'd2) ? mtvec_q[1:0]
                                                                     : i_csr_data[1:0]};
          c_ADDR_MENVCFG:       menvcfg_d       = i_csr_data;
          c_ADDR_MCOUNTINHIBIT: mcountinhibit_d = i_csr_data;
          c_ADDR_MSCRATCH:      mscratch_d      = i_csr_data;
          c_ADDR_MEPC:          mepc_d          = {i_csr_data[W-1:1], 1'b0};
          c_ADDR_MCAUSE:        mcause_d        = i_csr_data;
          c_ADDR_MTVAL:         mtval_d         = i_csr_data;
          c_ADDR_MIP:           mip_d           = i_csr_data;
          c_ADDR_MSECCFG:       mseccfg_d       = i_csr_data;
          c_ADDR_MCYCLE: begin
            if (c_IS64) mcycle_d = w_wdata64;
            else        mcycle_d = {mcycle_q[63:32], w_wdata64[31:0]};
          end
          c_ADDR_MINSTRET: begin
            if (c_IS64) minstret_d = w_wdata64;
            else        minstret_d = {minstret_q[63:32], w_wdata64[31:0]};
          end
          c_ADDR_MCYCLEH:       mcycle_d   = {w_wdata64[31:0], mcycle_q[31:0]};
          c_ADDR_MINSTRETH:     minstret_d = {w_wdata64[31:0], minstret_q[31:0]};
          default: begin
            for (int i = 0; i < 16; i++) begin
              if (f_is_pmpcfg(i_csr_write_addr) && (i_csr_write_addr[3:0] == 4'(i)))
                pmpcfg_d[i] = i_csr_data;
            end
            for (int i = 0; i < NUM_PMP_ADDR; i++) begin
              if (i_csr_write_addr == c_ADDR_PMPADDR0 + 12'(i))
                pmpaddr_d[i] = i_csr_data;
            end
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mstatus_mie_q   <= 1'b0;
      mstatus_mpie_q  <= 1'b0;
      medeleg_q       <= '0;
      mideleg_q       <= '0;
      mie_q           <= '0;
      mtvec_q         <= RESET_MTVEC[W-1:0];
      menvcfg_q       <= '0;
      mcountinhibit_q <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mip_q           <= '0;
      mseccfg_q       <= '0;
      for (int i = 0; i < 16; i++)           pmpcfg_q[i]  <= '0;
      for (int i = 0; i < NUM_PMP_ADDR; i++) pmpaddr_q[i] <= '0;
      mcycle_q        <= '0;
      minstret_q      <= '0;
      trap_taken_q    <= 1'b0;
    end else begin
      mstatus_mie_q   <= mstatus_mie_d;
      mstatus_mpie_q  <= mstatus_mpie_d;
      medeleg_q       <= medeleg_d;
      mideleg_q       <= mideleg_d;
      mie_q           <= mie_d;
      mtvec_q         <= mtvec_d;
      menvcfg_q       <= menvcfg_d;
      mcountinhibit_q <= mcountinhibit_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      mip_q           <= mip_d;
      mseccfg_q       <= mseccfg_d;
      for (int i = 0; i < 16; i++)           pmpcfg_q[i]  <= pmpcfg_d[i];
      for (int i = 0; i < NUM_PMP_ADDR; i++) pmpaddr_q[i] <= pmpaddr_d[i];
      mcycle_q        <= mcycle_d;
      minstret_q      <= minstret_d;
      trap_taken_q    <= trap_taken_d;
    end
  end

  assign o_trap_taken = trap_taken_q;
  assign o_mtvec      = {mtvec_q[W-1:2], 2'b00};
  assign o_mepc       = mepc_q;
  assign o_UXL        = c_IS64 ? 2'b10 : 2'(XLEN);

endmodule
`default_nettype wire

// File: tb/tb_m_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_csr_trap_unit
// Description : Scoreboard bench for m_csr_trap_unit (XLEN=2, 64-bit).
//               Stimulus pushes expected values; a negedge monitor pops and
//               compares them against the selected DUT output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_csr_trap_unit;

  localparam logic [3:0]  NO_E  = 4'hF;
  localparam logic [63:0] RSTV  = 64'h1000;
  localparam bit [12:0]   EN_PAT = 13'b1_1101_1011_1011;
  localparam bit [12:0]   IR_PAT = 13'b0_1010_1000_1101;

  localparam logic [2:0] S_DATA = 3'd0, S_ILL = 3'd1, S_MTVEC = 3'd2,
                         S_MEPC = 3'd3, S_TRAP = 3'd4, S_UXL = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [11:0] rd_addr;
  logic [63:0] rd_data;
  logic [11:0] wr_addr;
  logic        wr_en;
  logic [63:0] wr_data;
  logic [3:0]  code_fd, code_em;
  logic [63:0] pc_fd, pc_em, addr_em;
  logic        mret, instret;
  logic        trap_taken;
  logic [63:0] mtvec, mepc;
  logic [1:0]  uxl;
  logic        illegal;

  always #5 clk = ~clk;

  m_csr_trap_unit #(
    .XLEN(2), .NUM_PMP_ADDR(16), .NO_E(NO_E), .RESET_MTVEC(RSTV)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_csr_read_addr(rd_addr), .o_csr_data(rd_data),
    .i_csr_write_addr(wr_addr), .i_csr_write_enable(wr_en), .i_csr_data(wr_data),
    .i_exception_code_f_d_ff(code_fd), .i_exception_pc_f_d_ff(pc_fd),
    .i_exception_code_e_m_ff(code_em), .i_exception_pc_e_m_ff(pc_em),
    .i_exception_addr_e_m_ff(addr_em),
    .i_mret_e(mret), .i_instret(instret),
    .o_trap_taken(trap_taken), .o_mtvec(mtvec), .o_mepc(mepc),
    .o_UXL(uxl), .o_illegal_csr(illegal)
  );

  typedef struct packed { logic [2:0] sel; logic [63:0] val; } exp_t;
  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  // Monitor: everything queued during a cycle is checked at its falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      string       nm;
      logic [63:0] act;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e.sel)
        S_DATA:  act = rd_data;
        S_ILL:   act = {63'b0, illegal};
        S_MTVEC: act = mtvec;
        S_MEPC:  act = mepc;
        S_TRAP:  act = {63'b0, trap_taken};
        default: act = {62'b0, uxl};
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, e.val);
      end
    end
  end

  task automatic push(input logic [2:0] sel, input logic [63:0] val, input string nm);
    exp_q.push_back({sel, val});
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] v, input string nm);
    rd_addr = a;
    push(S_DATA, v, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    code_fd = NO_E;
    code_em = NO_E;
    mret    = 1'b0;
    instret = 1'b0;
    clk_en  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = 12'h300; wr_addr = 12'h0; wr_data = '0;
    pc_fd = '0; pc_em = '0; addr_em = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    push(S_TRAP, 0, "rst_trap"); push(S_MTVEC, RSTV, "rst_o_mtvec");
    push(S_MEPC, 0, "rst_o_mepc"); push(S_UXL, 2, "rst_uxl");
    rd(12'h300, 64'h2_0000_1800, "rst_mstatus"); push(S_ILL, 0, "rst_ill");
    step();
    rd(12'h301, 64'h8000_0000_0000_0100, "misa"); step();
    rd(12'h305, RSTV, "rst_mtvec"); step();

    // mtvec WARL
    wr(12'h305, 64'h8000_0003);
    rd(12'h305, 64'h8000_0000, "mtvec_mode3"); push(S_MTVEC, 64'h8000_0000, "o_mtvec_a"); step();
    wr(12'h305, 64'h4001);
    rd(12'h305, 64'h4001, "mtvec_mode1"); push(S_MTVEC, 64'h4000, "o_mtvec_b"); step();
    wr(12'h305, 64'h8000_0002);
    rd(12'h305, 64'h8000_0001, "mtvec_mode2_kept"); step();

    // Simultaneous E/M + F/D exception with a losing mscratch write
    wr(12'h340, 64'h1234);
    wr(12'h300, 64'h8);
    rd(12'h300, 64'h2_0000_1808, "mstatus_mie_set"); step();
    code_em = 4'd5; pc_em = 64'h100; addr_em = 64'hDEAD;
    code_fd = 4'd2; pc_fd = 64'h200;
    wr_en = 1'b1; wr_addr = 12'h340; wr_data = 64'h5555;
    push(S_TRAP, 0, "trap_cycle_no_pulse");
    step();
    idle();
    push(S_TRAP, 1, "trap_pulse"); push(S_MEPC, 64'h100, "o_mepc_em");
    rd(12'h341, 64'h100, "mepc_em"); step();
    push(S_TRAP, 0, "trap_pulse_end");
    rd(12'h342, 64'd5, "mcause_em"); step();
    rd(12'h343, 64'hDEAD, "mtval_em"); step();
    rd(12'h300, 64'h2_0000_1880, "mstatus_after_trap"); step();
    rd(12'h340, 64'h1234, "mscratch_kept"); step();

    // mret
    mret = 1'b1; step(); mret = 1'b0;
    rd(12'h300, 64'h2_0000_1888, "mstatus_mret"); push(S_TRAP, 0, "mret_no_pulse"); step();

    // F/D-only trap with odd pc
    code_fd = 4'd1; pc_fd = 64'h203; step(); idle();
    push(S_TRAP, 1, "fd_pulse"); push(S_MEPC, 64'h202, "o_mepc_fd");
    rd(12'h342, 64'd1, "mcause_fd"); step();
    rd(12'h343, 64'h203, "mtval_fd"); step();
    rd(12'h300, 64'h2_0000_1880, "mstatus_fd"); step();

    // Exception during a stall is ignored
    code_fd = 4'd3; pc_fd = 64'h400; clk_en = 1'b0; step(); idle();
    push(S_TRAP, 0, "stall_no_pulse"); push(S_MEPC, 64'h202, "stall_mepc_kept");
    rd(12'h342, 64'd1, "stall_mcause_kept"); step();

    // mepc bit0 forced low
    wr(12'h341, 64'h301);
    rd(12'h341, 64'h300, "mepc_wr"); push(S_MEPC, 64'h300, "o_mepc_wr"); step();

    // Counters: 10 enabled cycles, 4 counted retires, 3 stalls
    wr(12'hB02, 64'h0);
    wr(12'hB00, 64'h0);
    for (int i = 0; i < 13; i++) begin
      clk_en  = EN_PAT[i];
      instret = IR_PAT[i];
      step();
    end
    clk_en = 1'b0; instret = 1'b0;
    rd(12'hB00, 64'd10, "mcycle_cnt"); step();
    rd(12'hB02, 64'd4, "minstret_cnt"); step();
    clk_en = 1'b1;
    wr(12'h320, 64'd5);
    instret = 1'b1; repeat (5) step(); instret = 1'b0;
    clk_en = 1'b0;
    rd(12'hB00, 64'd11, "mcycle_inhibit"); step();
    rd(12'hB02, 64'd4, "minstret_inhibit"); step();
    clk_en = 1'b1;
    wr(12'h320, 64'd0);
    wr(12'hB00, '1);
    rd(12'hB00, '1, "mcycle_wr_beats_inc"); step();
    clk_en = 1'b0;
    rd(12'hB00, 64'd0, "mcycle_wrap"); step();
    clk_en = 1'b1;

    // Illegal accesses
    wr_en = 1'b1; wr_addr = 12'hF14; wr_data = 64'h77;
    rd(12'hF14, 64'd0, "ro_wr_data"); push(S_ILL, 1, "ro_wr_ill"); step();
    wr_en = 1'b0;
    rd(12'hF14, 64'd0, "ro_rd_data"); push(S_ILL, 0, "ro_rd_ill"); step();
    rd(12'h3FF, 64'd0, "pmpaddr_oob_data"); push(S_ILL, 1, "pmpaddr_oob_ill"); step();
    wr(12'h3BF, 64'hABC);
    rd(12'h3BF, 64'hABC, "pmpaddr15"); push(S_ILL, 0, "pmpaddr15_ill"); step();
    rd(12'h3A1, 64'd0, "pmpcfg_odd_data"); push(S_ILL, 1, "pmpcfg_odd_ill"); step();
    wr(12'h3A2, 64'h77);
    rd(12'h3A2, 64'h77, "pmpcfg2"); push(S_ILL, 0, "pmpcfg2_ill"); step();
    wr_en = 1'b1; wr_addr = 12'h301; wr_data = 64'h0;
    rd(12'h301, 64'h8000_0000_0000_0100, "misa_wr_kept"); push(S_ILL, 1, "misa_wr_ill"); step();
    wr_en = 1'b0;

    // Reset in the middle of a trap cycle
    code_em = 4'd7; pc_em = 64'h500; addr_em = 64'h9;
    rst = 1'b1;
    step();
    idle(); rst = 1'b0;
    push(S_TRAP, 0, "rst_mid_trap_pulse"); push(S_MEPC, 0, "rst_mid_trap_mepc");
    push(S_MTVEC, RSTV, "rst_mid_trap_mtvec");
    rd(12'h342, 64'd0, "rst_mid_trap_mcause"); step();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
